// File: rtl/mdu.sv
// Multiply/divide unit: one long-latency op at a time, results in HI/LO.
// The result is computed at accept and held until the final busy edge.
module mdu #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MADDU = 3'd7;

  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;

  logic               mul_signed_s, div_signed_s, a_neg_s, b_neg_s;
  logic [2*WIDTH-1:0] a_ext_s, b_ext_s, prod_s, res_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s, b_safe_s, uq_s, ur_s, q_s, r_s;

  // Arithmetic on the live inputs; only consumed on the accept edge.
  always_comb begin
    mul_signed_s = (op == OP_MULT) || (op == OP_MADD);
    div_signed_s = (op == OP_DIV);
    a_ext_s      = {{WIDTH{mul_signed_s & a[WIDTH-1]}}, a};
    b_ext_s      = {{WIDTH{mul_signed_s & b[WIDTH-1]}}, b};
    // Truncating the sign-extended product to 2*WIDTH gives the signed product.
    prod_s       = a_ext_s * b_ext_s;
    a_neg_s      = div_signed_s & a[WIDTH-1];
    b_neg_s      = div_signed_s & b[WIDTH-1];
    a_mag_s      = a_neg_s ? (~a + ONE_W) : a;
    b_mag_s      = b_neg_s ? (~b + ONE_W) : b;
    b_safe_s     = (b == {WIDTH{1'b0}}) ? ONE_W : b_mag_s;
    uq_s         = a_mag_s / b_safe_s;
    ur_s         = a_mag_s % b_safe_s;
    // min/-1 falls out naturally: magnitude 2^(W-1) re-negates to itself.
    q_s          = (a_neg_s ^ b_neg_s) ? (~uq_s + ONE_W) : uq_s;
    r_s          = a_neg_s ? (~ur_s + ONE_W) : ur_s;
    case (op)
      OP_MULT, OP_MULTU: res_s = prod_s;
      OP_MADD, OP_MADDU: res_s = {hi_q, lo_q} + prod_s;
      OP_DIV, OP_DIVU: begin
        if (b == {WIDTH{1'b0}}) begin
          res_s = {a, {WIDTH{1'b1}}};
        end else begin
          res_s = {r_s, q_s};
        end
      end
      default: res_s = {hi_q, lo_q};
    endcase
  end

  // Next-state logic for the IDLE/RUN sequencer and HI/LO.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: begin
              state_d = S_RUN;
              res_d   = res_s;
              if ((op == OP_DIV) || (op == OP_DIVU)) begin
                cnt_d = CW'(DIV_CYCLES);
              end else begin
                cnt_d = CW'(MUL_CYCLES);
              end
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          cnt_d   = {CW{1'b0}};
          hi_d    = res_q[2*WIDTH-1:WIDTH];
          lo_d    = res_q[WIDTH-1:0];
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= {CW{1'b0}};
      res_q   <= {(2*WIDTH){1'b0}};
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Bench for mdu: 32-bit default instance plus a 16-bit single-cycle instance,
// vector tables with a done-driven scoreboard and hand-written corner sequences.
module tb_mdu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, busy, done;
  logic [2:0]  op;
  logic [31:0] a, b, hi, lo;
  logic        start16, busy16, done16;
  logic [2:0]  op16;
  logic [15:0] a16, b16, hi16, lo16;

  mdu dut32 (.clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
             .busy(busy), .done(done), .hi(hi), .lo(lo));

  mdu #(.WIDTH(16), .MUL_CYCLES(1), .DIV_CYCLES(1)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .op(op16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .hi(hi16), .lo(lo16));

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, eh, el;
    int          n;
  } vec_t;

  vec_t        v32[13];
  vec_t        v16[9];
  int          total = 0, bad = 0;
  logic [63:0] q32[$];
  logic [31:0] q16[$];
  int          done_cnt32 = 0, exp_done32 = 0, done_cnt16 = 0, exp_done16 = 0;
  int          n;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt32++;
      if (q32.size() == 0) begin
        total++; bad++;
        $display("FAIL done32_unexpected actual=1 required=0");
      end else begin
        chk("result32", {hi, lo}, q32.pop_front());
      end
    end
    if (done16 === 1'b1) begin
      done_cnt16++;
      if (q16.size() == 0) begin
        total++; bad++;
        $display("FAIL done16_unexpected actual=1 required=0");
      end else begin
        chk("result16", 64'({hi16, lo16}), 64'(q16.pop_front()));
      end
    end
  end

  task automatic issue32(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit push, input logic [63:0] e);
    op = o; a = x; b = y; start = 1'b1;
    if (push) begin q32.push_back(e); exp_done32++; end
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
  endtask

  task automatic issue16(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                         input bit push, input logic [31:0] e);
    op16 = o; a16 = x; b16 = y; start16 = 1'b1;
    if (push) begin q16.push_back(e); exp_done16++; end
    @(negedge clk);
    start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
  endtask

  task automatic count_busy32(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin cnt++; @(negedge clk); end
  endtask

  task automatic count_busy16(output int cnt);
    cnt = 0;
    while (busy16 === 1'b1 && cnt < 100) begin cnt++; @(negedge clk); end
  endtask

  initial begin
    v32[0]  = '{3'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 5};
    v32[1]  = '{3'd1, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
    v32[2]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    v32[3]  = '{3'd3, 32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF, 10};
    v32[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    v32[5]  = '{3'd4, 32'd0,        32'd9,        32'h00000000, 32'h80000000, 0};
    v32[6]  = '{3'd5, 32'd5,        32'd9,        32'h00000000, 32'h00000005, 0};
    v32[7]  = '{3'd6, 32'd2,        32'd3,        32'h00000000, 32'h0000000B, 5};
    v32[8]  = '{3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h0000000C, 5};
    v32[9]  = '{3'd3, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10};
    v32[10] = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    v32[11] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
    v32[12] = '{3'd6, 32'hFFFFFFFF, 32'd1,        32'h3FFFFFFF, 32'hFFFFFFFF, 5};

    v16[0] = '{3'd0, 32'hFFFD, 32'd7,    32'hFFFF, 32'hFFEB, 1};
    v16[1] = '{3'd1, 32'hFFFF, 32'd2,    32'h0001, 32'hFFFE, 1};
    v16[2] = '{3'd2, 32'hFFF9, 32'd2,    32'hFFFF, 32'hFFFD, 1};
    v16[3] = '{3'd3, 32'd7,    32'd0,    32'h0007, 32'hFFFF, 1};
    v16[4] = '{3'd2, 32'h8000, 32'hFFFF, 32'h0000, 32'h8000, 1};
    v16[5] = '{3'd4, 32'd0,    32'd0,    32'h0000, 32'h8000, 0};
    v16[6] = '{3'd5, 32'd5,    32'd0,    32'h0000, 32'h0005, 0};
    v16[7] = '{3'd6, 32'd2,    32'd3,    32'h0000, 32'h000B, 1};
    v16[8] = '{3'd7, 32'hFFFF, 32'hFFFF, 32'hFFFE, 32'h000C, 1};

    reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    start16 = 1'b0; op16 = 3'd0; a16 = 16'd0; b16 = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy32", 64'(busy), 64'd0);
    chk("rst_done32", 64'(done), 64'd0);
    chk("rst_hilo32", {hi, lo}, 64'd0);
    chk("rst_busy16", 64'(busy16), 64'd0);
    chk("rst_hilo16", 64'({hi16, lo16}), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      issue32(v32[i].op, v32[i].a, v32[i].b, v32[i].n != 0, {v32[i].eh, v32[i].el});
      count_busy32(n);
      chk("busy_len32", 64'(n), 64'(v32[i].n));
      if (v32[i].n == 0) begin
        chk("move32_hilo", {hi, lo}, {v32[i].eh, v32[i].el});
        chk("move32_done", 64'(done), 64'd0);
      end
    end

    // Interfering MULT and MTHI while busy must be ignored.
    issue32(3'd0, 32'd6, 32'd7, 1'b1, {32'd0, 32'd42});
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (n == 1) begin
        start = 1'b1; op = 3'd0; a = 32'd1; b = 32'd1;
      end else if (n == 2) begin
        op = 3'd4; a = 32'hDEAD;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    chk("ignore_busy_len", 64'(n), 64'd5);
    chk("ignore_hilo", {hi, lo}, {32'd0, 32'd42});
    @(negedge clk);
    chk("ignore_no_restart", 64'(busy), 64'd0);

    // Reset in the third busy cycle of a DIV aborts it.
    issue32(3'd2, 32'd100, 32'd7, 1'b0, 64'd0);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (n == 3) begin
        reset = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_hilo_later", {hi, lo}, 64'd0);

    // Back-to-back MULT then DIV with start in the cycle busy falls.
    issue32(3'd0, 32'hFFFFFFFF, 32'd5, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFB});
    count_busy32(n);
    chk("b2b_mul_len", 64'(n), 64'd5);
    chk("b2b_done", 64'(done), 64'd1);
    issue32(3'd3, 32'd100, 32'd7, 1'b1, {32'd2, 32'd14});
    chk("b2b_no_idle", 64'(busy), 64'd1);
    count_busy32(n);
    chk("b2b_div_len", 64'(n), 64'd10);
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      issue16(v16[i].op, v16[i].a[15:0], v16[i].b[15:0], v16[i].n != 0,
              {v16[i].eh[15:0], v16[i].el[15:0]});
      count_busy16(n);
      chk("busy_len16", 64'(n), 64'(v16[i].n));
      if (v16[i].n == 0) begin
        chk("move16_hilo", 64'({hi16, lo16}), 64'({v16[i].eh[15:0], v16[i].el[15:0]}));
      end
    end
    repeat (3) @(negedge clk);

    chk("sb32_empty", 64'(q32.size()), 64'd0);
    chk("done32_count", 64'(done_cnt32), 64'(exp_done32));
    chk("sb16_empty", 64'(q16.size()), 64'd0);
    chk("done16_count", 64'(done_cnt16), 64'(exp_done16));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Parametrised multiply/divide unit that runs beside the combinational ALU in the execute stage. It accepts one long-latency operation at a time and holds its result in architectural HI/LO registers. A `busy` flag lets the hazard unit stall dependent instructions. It adds signed/unsigned multiply, divide, multiply-accumulate and HI/LO moves, with latencies fixed by parameters.

## Interface
- `WIDTH`, 32: operand and HI/LO width; ≥ 2.
- `MUL_CYCLES`, 5: busy duration for multiply and multiply-accumulate ops; ≥ 1.
- `DIV_CYCLES`, 10: busy duration for divide ops; ≥ 1.

- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request strobe; sampled every edge.
- `op` in 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD (signed), 7 MADDU.
- `a` in WIDTH: rs operand (multiplicand, dividend, or move source).
- `b` in WIDTH: rt operand (multiplier or divisor).
- `busy` out 1: operation in flight.
- `done` out 1: one-cycle pulse on the cycle after HI/LO update.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation
- Accept condition: `start && !busy && !reset` at an edge. When `busy` is high, `start` is ignored and nothing is queued.
- On accept, `a`, `b` and `op` are latched. Later changes to the inputs have no effect.
- MULT/MULTU: 2·WIDTH-bit product, signed or unsigned; {HI,LO} = product.
- MADD/MADDU: {HI,LO} = {HI,LO} + product, taken modulo 2^(2·WIDTH).
  - The accumulator value used is the one present at the end of the op.
  - No move can intervene while busy, so this is the value at accept.
- DIV/DIVU: LO = quotient, HI = remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - Divide by zero: LO = all ones, HI = `a`. No trap is raised.
  - Signed overflow (a = −2^(WIDTH−1), b = −1): LO = a, HI = 0.
- MTHI/MTLO: write `a` into HI or LO at the accept edge. `busy` stays 0 and `done` is not pulsed.
- States:
  - IDLE → on accept of op 0–3 or 6–7: load counter with MUL_CYCLES or DIV_CYCLES, go to RUN.
  - RUN: decrement counter each edge. At the edge where counter == 1, write HI/LO, go to IDLE, set `done`.
- Implementation freedom: the arithmetic may be iterative or a single-cycle datapath with the result held until the final edge. HI/LO must not change before the final edge.

## Timing
- Reset values: `busy` = 0, `done` = 0, `hi` = 0, `lo` = 0, state IDLE, counter 0.
- Reset mid-operation aborts the op. HI/LO go to 0 and no `done` pulse occurs.
- Accept at edge E0:
  - `busy` = 1 from after E0 until after edge E0+N, where N = MUL_CYCLES or DIV_CYCLES.
  - `busy` is therefore high for exactly N cycles.
- HI/LO take their new value after edge E0+N. In the same cycle `busy` = 0 and `done` = 1. `done` = 0 after the next edge.
- Back-to-back: `start` may be asserted in the cycle where `busy` has fallen. That op is accepted at the following edge, giving zero idle cycles between ops.
- Move while busy: ignored, and HI/LO are unchanged. The hazard unit is responsible for stalling such moves.
- `hi`/`lo` are register outputs. Reads are combinational from these registers, so there is no read latency.

## Test plan
- Reset, then MULT with a=0xFFFFFFFD (−3), b=7:
  - `busy` is high for exactly 5 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFEB, and `done` pulses once.
- MULTU with a=0xFFFFFFFF, b=2 → hi=0x00000001, lo=0xFFFFFFFE.
- DIV with a=0xFFFFFFF9 (−7), b=2:
  - After 10 busy cycles: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU with a=7, b=0 → lo=0xFFFFFFFF, hi=7.
  - DIV with a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI a=0, MTLO a=5, then MADD a=2, b=3 → hi=0, lo=11.
  - Then MADDU a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x0000000C.
- Inputs changed after accept:
  - `start` with op=MULT pulsed while busy, and MTHI issued while busy → both ignored; the original result and busy length are unchanged.
- `reset` asserted in the 3rd busy cycle of a DIV:
  - Next cycle: busy=0, hi=lo=0, and no `done` pulse.
- Back-to-back MULT→DIV with `start` asserted in the cycle `busy` falls → second op accepted at the following edge, with no idle cycle between the two.
- Rerun with parameters WIDTH=16, MUL_CYCLES=1, DIV_CYCLES=1 → correct 16-bit results and single-cycle busy.
